dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
- In-order FIFO between the info decoder and the reservation stations / ROB.
- Buffers decoded instruction bundles, one per cycle. The decoder supplies the control payload, station select, station-request flag and ROB-write flag.
- Releases the head bundle only when the targeted reservation station and the ROB can both accept it.
- Absorbs back-pressure so fetch/decode stall cleanly; supports a full flush on mispredict.

Parameters:
- DEPTH, 4: number of bundle entries; power of two, ≥2.
- PAYLOAD_W, 64: width of opaque decoded payload (aluOp, immSrc, flags, destReg, pc, imm…).

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset
- flush  in  1  discard all entries (mispredict)
- enq_valid  in  1  decoder presents a bundle
- enq_ready  out  1  queue can accept this cycle
- enq_station  in  2  RSstation code: 00 ALU, 01 branch, 10 reserved, 11 LUI/AUIPC/store unit
- enq_station_req  in  1  bundle needs a reservation-station slot
- enq_rob_write  in  1  bundle needs a ROB entry
- enq_payload  in  PAYLOAD_W  decoded bundle
- rs_ready  in  4  per-station accept, indexed by station code
- rob_ready  in  1  ROB can allocate
- deq_valid  out  1  head entry present
- deq_fire  out  1  head dispatched this cycle
- deq_station  out  2  head station code
- deq_station_req  out  1  head needs a station
- deq_rob_write  out  1  head needs ROB
- deq_payload  out  PAYLOAD_W  head bundle
- count  out  $clog2(DEPTH)+1  occupancy
- stall_cycles  out  16  saturating count of cycles with deq_valid=1 and deq_fire=0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - head and tail pointers = 0; count = 0; stall_cycles = 0.
  - deq_valid = 0; deq_fire = 0; enq_ready = 1.
  - Entry storage is not reset. deq_* fields are don't-care while deq_valid = 0.
- Storage: circular buffer; head/tail pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.
- Enqueue handshake:
  - enq_ready = !full, registered-state only. No same-cycle bypass of a dequeue freeing a slot.
  - Enqueue occurs on a clk edge when enq_valid && enq_ready && !flush.
  - enq_valid while full: the bundle is not taken. The decoder holds it stable until enq_ready.
- Latency: an enqueued bundle is visible at deq_* on the next cycle at the earliest. There is no enq→deq combinational path.
- Dispatch condition, all combinational from registered head plus ready inputs:
  - deq_fire = deq_valid && !flush && (!deq_rob_write || rob_ready) && (!deq_station_req || rs_ready[deq_station]).
  - In-order only. A blocked head blocks all younger entries.
  - Bundles with deq_station_req = 0 and deq_rob_write = 0 (e.g. loads, per current decode) fire whenever deq_valid.
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
- Full with deq_fire: count becomes DEPTH-1 next cycle; enq_ready rises next cycle.
- flush:
  - Synchronous, highest priority.
  - Next cycle: count = 0, head = tail = 0, deq_valid = 0.
  - Any same-cycle enqueue is dropped; deq_fire is forced 0.
  - stall_cycles is unaffected.
- stall_cycles: increments by 1 per cycle with deq_valid && !deq_fire && !flush; saturates at 16'hFFFF.
- Reset mid-operation: asynchronous clear to the reset state regardless of handshake in flight.
- Illegal station code 10 with station_req = 1: dispatch waits on rs_ready[2] as written; no special handling.

Test Plan:
- Reset, then enqueue 3 bundles with station 00, station_req=1, rob_write=1, payloads 0x11/0x22/0x33, with rs_ready=4'b0001 and rob_ready=1 → deq_fire on 3 consecutive cycles beginning 1 cycle after the first enqueue, payloads in order, count returns to 0.
- Fill to DEPTH=4 with rs_ready=0 → enq_ready=0 at count=4 and a 5th enq_valid is ignored. Then set rs_ready[0]=1 → one fire per cycle; enq_ready=1 the cycle after the first fire.
- Head is station 01, next entry is station 00, rs_ready=4'b0001 → no fire (in-order block) and stall_cycles increments each cycle. Raise rs_ready[1] → both fire on consecutive cycles.
- Head has station_req=0, rob_write=0 (load), with rob_ready=0 and rs_ready=0 → fires immediately.
- With count=3, assert flush together with enq_valid=1 → next cycle count=0, deq_valid=0, the enqueued bundle never appears.
- Enqueue 6 bundles while firing continuously → pointers wrap past DEPTH and payload order is preserved. Assert reset_n=0 mid-stream → outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/dispatch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue_if
// Brief    : Handshake bundle between the decoder, the dispatch queue and the
//            reservation stations / ROB.
// Revision : 1.0 - initial release
// ============================================================================
interface dispatch_queue_if #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                 flush;
    logic                 enq_valid;
    logic                 enq_ready;
    logic [1:0]           enq_station;
    logic                 enq_station_req;
    logic                 enq_rob_write;
    logic [PAYLOAD_W-1:0] enq_payload;
    logic [3:0]           rs_ready;
    logic                 rob_ready;
    logic                 deq_valid;
    logic                 deq_fire;
    logic [1:0]           deq_station;
    logic                 deq_station_req;
    logic                 deq_rob_write;
    logic [PAYLOAD_W-1:0] deq_payload;
    logic [c_CNT_W-1:0]   count;
    logic [15:0]          stall_cycles;

    modport master (
        output flush, enq_valid, enq_station, enq_station_req, enq_rob_write,
               enq_payload, rs_ready, rob_ready,
        input  enq_ready, deq_valid, deq_fire, deq_station, deq_station_req,
               deq_rob_write, deq_payload, count, stall_cycles
    );

    modport slave (
        input  flush, enq_valid, enq_station, enq_station_req, enq_rob_write,
               enq_payload, rs_ready, rob_ready,
        output enq_ready, deq_valid, deq_fire, deq_station, deq_station_req,
               deq_rob_write, deq_payload, count, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_queue
// Brief    : In-order bundle FIFO from decode to reservation stations / ROB,
//            with flush and a saturating head-stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    dispatch_queue_if.slave dq
);
    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [1:0]           r_station [DEPTH];
    logic                 r_sreq    [DEPTH];
    logic                 r_rwr     [DEPTH];

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [15:0]        r_stall;

    logic w_full;
    logic w_valid;
    logic w_enq;
    logic w_fire;

    // Status is derived only from registered state: no enq->deq or deq->enq bypass.
    assign w_full  = (r_count == c_FULL);
    assign w_valid = (r_count != '0);
    assign w_enq   = dq.enq_valid && !w_full && !dq.flush;
    assign w_fire  = w_valid && !dq.flush
                   && (!r_rwr[r_head]  || dq.rob_ready)
                   && (!r_sreq[r_head] || dq.rs_ready[r_station[r_head]]);

    assign dq.enq_ready       = !w_full;
    assign dq.deq_valid       = w_valid;
    assign dq.deq_fire        = w_fire;
    assign dq.deq_station     = r_station[r_head];
    assign dq.deq_station_req = r_sreq[r_head];
    assign dq.deq_rob_write   = r_rwr[r_head];
    assign dq.deq_payload     = r_payload[r_head];
    assign dq.count           = r_count;
    assign dq.stall_cycles    = r_stall;

    // Entry storage carries no reset; contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_payload[r_tail] <= dq.enq_payload;
            r_station[r_tail] <= dq.enq_station;
            r_sreq[r_tail]    <= dq.enq_station_req;
            r_rwr[r_tail]     <= dq.enq_rob_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (dq.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_fire) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush cycles are not counted as stalls even though the head is not fired.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_valid && !w_fire && !dq.flush && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_queue
// Brief    : Directed and randomized check of dispatch_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int PW    = 64;

    typedef struct {
        logic [1:0]    st;
        logic          req;
        logic          rob;
        logic [PW-1:0] pl;
    } ent_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    ent_t q[$];
    int   exp_stall = 0;

    dispatch_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dq ();

    dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dq      (dq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic req, input logic rob,
                         input logic [PW-1:0] pl, input logic [3:0] rs, input logic robr,
                         input logic fl);
        dq.enq_valid       = v;
        dq.enq_station     = st;
        dq.enq_station_req = req;
        dq.enq_rob_write   = rob;
        dq.enq_payload     = pl;
        dq.rs_ready        = rs;
        dq.rob_ready       = robr;
        dq.flush           = fl;
    endtask

    task automatic check_reset();
        check("rst_count",   64'(dq.count), 64'd0);
        check("rst_valid",   64'(dq.deq_valid), 64'd0);
        check("rst_fire",    64'(dq.deq_fire), 64'd0);
        check("rst_ready",   64'(dq.enq_ready), 64'd1);
        check("rst_stall",   64'(dq.stall_cycles), 64'd0);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        logic fire;
        logic acc;
        ent_t h;
        ent_t n;
        @(negedge clk);
        fire = 1'b0;
        if (q.size() > 0) begin
            h    = q[0];
            fire = !dq.flush && (!h.rob || dq.rob_ready) && (!h.req || dq.rs_ready[h.st]);
        end
        check("enq_ready",    64'(dq.enq_ready), 64'(q.size() < DEPTH));
        check("deq_valid",    64'(dq.deq_valid), 64'(q.size() > 0));
        check("deq_fire",     64'(dq.deq_fire), 64'(fire));
        check("count",        64'(dq.count), 64'(q.size()));
        check("stall_cycles", 64'(dq.stall_cycles), 64'(exp_stall));
        if (q.size() > 0) begin
            check("deq_payload", dq.deq_payload, h.pl);
            check("deq_station", 64'(dq.deq_station), 64'(h.st));
            check("deq_req",     64'(dq.deq_station_req), 64'(h.req));
            check("deq_rob",     64'(dq.deq_rob_write), 64'(h.rob));
        end
        @(posedge clk);
        if (dq.flush) begin
            q.delete();
        end else begin
            acc = dq.enq_valid && (q.size() < DEPTH);
            n   = '{st: dq.enq_station, req: dq.enq_station_req, rob: dq.enq_rob_write,
                    pl: dq.enq_payload};
            if (q.size() > 0 && !fire && exp_stall < 65535) exp_stall++;
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(n);
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] rs, input logic robr, input int n);
        drive(1'b0, 2'd0, 1'b0, 1'b0, '0, rs, robr, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        drive(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
        #2;
        check_reset();
        #10 reset_n = 1'b1;
        step();

        // Three ALU bundles streaming straight through.
        drive(1'b1, 2'd0, 1'b1, 1'b1, 64'h11, 4'b0001, 1'b1, 1'b0); step();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 64'h22, 4'b0001, 1'b1, 1'b0); step();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 64'h33, 4'b0001, 1'b1, 1'b0); step();
        idle(4'b0001, 1'b1, 3);

        // Fill with stations blocked; fifth offer is refused, then drain.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 1'b1, 1'b1, 64'(32'hA0 + i), 4'b0000, 1'b1, 1'b0);
            step();
        end
        idle(4'b0001, 1'b1, 5);

        // Branch head blocks a ready ALU entry behind it.
        drive(1'b1, 2'd1, 1'b1, 1'b1, 64'hB1, 4'b0001, 1'b1, 1'b0); step();
        drive(1'b1, 2'd0, 1'b1, 1'b1, 64'hB2, 4'b0001, 1'b1, 1'b0); step();
        idle(4'b0001, 1'b1, 3);
        idle(4'b0011, 1'b1, 3);

        // Load-like bundle fires with nothing ready.
        drive(1'b1, 2'd2, 1'b0, 1'b0, 64'hC0DE, 4'b0000, 1'b0, 1'b0); step();
        idle(4'b0000, 1'b0, 2);

        // Flush at count 3 with a concurrent enqueue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 1'b1, 1'b1, 64'(32'hD0 + i), 4'b0000, 1'b1, 1'b0);
            step();
        end
        drive(1'b1, 2'd3, 1'b1, 1'b1, 64'hDEAD, 4'b1111, 1'b1, 1'b1); step();
        idle(4'b1111, 1'b1, 2);

        // Six back-to-back bundles wrap the pointers.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'(i), 1'b1, 1'b1, 64'(32'hE0 + i), 4'b1111, 1'b1, 1'b0);
            step();
        end
        idle(4'b1111, 1'b1, 2);

        // Randomized traffic with an asynchronous reset mid-stream.
        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                drive(1'b1, 2'd0, 1'b1, 1'b1, 64'h5A5A, 4'b0000, 1'b1, 1'b0);
                step();
                #2 reset_n = 1'b0;
                #1;
                check_reset();
                q.delete();
                exp_stall = 0;
                @(posedge clk);
                #3 reset_n = 1'b1;
            end
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 40) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
